// File: rtl/core4_oci_dct_pkg.sv
// Shared sizing and FSM state encoding for the OCI data-trace packer.
package core4_oci_dct_pkg;
  localparam int SLOTS   = 15;
  localparam int CODE_W  = 2;
  localparam int BUF_W   = SLOTS * CODE_W;
  localparam int CNT_W   = $clog2(SLOTS + 1);
  localparam int FRAME_W = CNT_W + BUF_W;

  typedef enum logic [1:0] {
    PACK   = 2'd0,
    ENDING = 2'd1,
    ENDED  = 2'd2
  } state_t;
endpackage

// File: rtl/core4_oci_dct_frame_reg.sv
// One-entry valid/ready holding register for completed trace frames.
module core4_oci_dct_frame_reg
  import core4_oci_dct_pkg::*;
#(
  parameter int DATA_W = FRAME_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // A load on the accept edge keeps valid high with the new contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/core4_cpu_0_oci_dct_packer.sv
// Packs 2-bit data-trace codes into 15-slot buffers and hands them off as frames.
// Optional feature macro: CORE4_OCI_DCT_OVERFLOW_EN (drop-and-count instead of backpressure).
module core4_cpu_0_oci_dct_packer
  import core4_oci_dct_pkg::*;
#(
  parameter int SLOTS  = core4_oci_dct_pkg::SLOTS,
  parameter int CODE_W = core4_oci_dct_pkg::CODE_W
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      code_valid,
  input  logic [CODE_W-1:0]                         code,
  output logic                                      code_ready,
  input  logic                                      flush_req,
  input  logic                                      stop_req,
  output logic [SLOTS*CODE_W-1:0]                   dct_buffer,
  output logic [$clog2(SLOTS+1)-1:0]                dct_count,
  output logic                                      frame_valid,
  input  logic                                      frame_ready,
  output logic [$clog2(SLOTS+1)+SLOTS*CODE_W-1:0]   frame_data,
  output logic                                      test_ending,
  output logic                                      test_has_ended
`ifdef CORE4_OCI_DCT_OVERFLOW_EN
  ,
  output logic [7:0]                                ovf_count
`endif
);

  localparam int BW = SLOTS * CODE_W;
  localparam int CW = $clog2(SLOTS + 1);

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [BW-1:0]   buffer, buffer_next;
  logic            flush_pend, flush_pend_next;
  logic            packable, accept, move, frame_free, has_data;

  assign packable   = (state == PACK) && (count < CW'(SLOTS)) && !flush_pend;
`ifdef CORE4_OCI_DCT_OVERFLOW_EN
  assign code_ready = (state == PACK);
`else
  assign code_ready = packable;
`endif
  assign accept     = code_valid && code_ready && packable;
  assign has_data   = (count != '0);
  assign frame_free = !frame_valid || frame_ready;
  // Codes are never accepted on a move edge: a move needs full, flush_pend or ENDING.
  assign move       = frame_free &&
                      ((count == CW'(SLOTS)) || ((flush_pend || state == ENDING) && has_data));

  always_comb begin
    count_next      = count;
    buffer_next     = buffer;
    flush_pend_next = flush_pend;
    state_next      = state;
    if (move) begin
      count_next  = '0;
      buffer_next = '0;
    end else if (accept) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (count == CW'(i)) buffer_next[i*CODE_W +: CODE_W] = code;
      end
      count_next = count + 1'b1;
    end
    if (move || !has_data) flush_pend_next = 1'b0;
    if (flush_req && state == PACK) flush_pend_next = 1'b1;
    case (state)
      PACK:    if (stop_req) state_next = ENDING;
      ENDING:  if (!has_data && !frame_valid) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = PACK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PACK;
      count      <= '0;
      buffer     <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      buffer     <= buffer_next;
      flush_pend <= flush_pend_next;
    end
  end

  core4_oci_dct_frame_reg #(.DATA_W(CW + BW)) u_frame_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (move),
    .load_data ({count, buffer}),
    .ready     (frame_ready),
    .valid     (frame_valid),
    .data      (frame_data)
  );

  assign dct_buffer     = buffer;
  assign dct_count      = count;
  assign test_ending    = (state == ENDING);
  assign test_has_ended = (state == ENDED);

`ifdef CORE4_OCI_DCT_OVERFLOW_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= 8'd0;
    end else if (code_valid && state == PACK && !packable) begin
      ovf_count <= sat_inc(ovf_count);
    end
  end
`endif

endmodule
